// File: rtl/prbs_checker.sv
// Frame checker: learns a 4-byte block, checks its repeats, then checks a PRBS7 tail.
// Optional macro PRBS_CHECK_EN enables the PRBS7 comparison; without it PRBS bytes are only counted.
module prbs_checker #(
    parameter int PRBS_BYTES = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  IN,
    input  logic        in_valid,
    input  logic [7:0]  n_pattern,
    output logic [31:0] pattern,
    output logic        err,
    output logic [7:0]  err_cnt,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

    // Input handshake: IN and n_pattern are consumed on a rising edge only when in_valid=1;
    // in_valid=0 is a stall and leaves every register untouched (err/done read low).

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEARN   = 2'd1,
        PATTERN = 2'd2,
        PRBS    = 2'd3
    } state_t;

    localparam logic [9:0] PRBS_LAST = 10'(PRBS_BYTES - 1);
    localparam bit         ONE_PRBS  = (PRBS_BYTES == 1);

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [7:0]  np_q, np_d;
    logic [31:0] pattern_q, pattern_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [9:0]  pat_last;
    logic        pat_last_hit;
    logic        prbs_last_hit;
    logic [7:0]  pat_byte;
    logic        prbs_mis;
    logic        mis;

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic inc);
        sat_inc = (cnt == 8'hFF) ? cnt : cnt + {7'd0, inc};
    endfunction

`ifdef PRBS_CHECK_EN
    localparam logic [6:0] LFSR_SEED = 7'h7F;

    logic [6:0] lfsr_q, lfsr_d;
    logic [6:0] lfsr_src;
    logic [6:0] lfsr_next;
    logic [7:0] prbs_exp;

    // Eight steps of x^7+x^6+1; the first generated bit lands in bit 7.
    function automatic logic [14:0] lfsr_step8(input logic [6:0] seed);
        logic [6:0] s;
        logic [7:0] b;
        logic       nb;
        s = seed;
        b = 8'd0;
        for (int i = 0; i < 8; i++) begin
            nb = s[6] ^ s[5];
            b  = {b[6:0], nb};
            s  = {s[5:0], nb};
        end
        lfsr_step8 = {s, b};
    endfunction

    always_comb begin
        lfsr_src              = (state_q == IDLE) ? LFSR_SEED : lfsr_q;
        {lfsr_next, prbs_exp} = lfsr_step8(lfsr_src);
        prbs_mis              = (IN != prbs_exp);
    end

    // Reseed at every frame start; advance only on PRBS bytes actually consumed.
    always_comb begin
        lfsr_d = lfsr_q;
        if (in_valid) begin
            if (state_q == IDLE) begin
                lfsr_d = (n_pattern == 8'd0) ? lfsr_next : LFSR_SEED;
            end else if (state_q == PRBS) begin
                lfsr_d = lfsr_next;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign prbs_mis = 1'b0;
`endif

    always_comb begin
        pat_last      = {np_q - 8'd1, 2'b00} - 10'd1;
        pat_last_hit  = (cnt_q == pat_last);
        prbs_last_hit = (cnt_q == PRBS_LAST);
        case (cnt_q[1:0])
            2'd0:    pat_byte = pattern_q[31:24];
            2'd1:    pat_byte = pattern_q[23:16];
            2'd2:    pat_byte = pattern_q[15:8];
            default: pat_byte = pattern_q[7:0];
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    if (n_pattern != 8'd0) begin
                        state_d = LEARN;
                    end else if (ONE_PRBS) begin
                        state_d = IDLE;
                    end else begin
                        state_d = PRBS;
                    end
                end
                LEARN: begin
                    if (cnt_q[1:0] == 2'd3) begin
                        state_d = (np_q > 8'd1) ? PATTERN : PRBS;
                    end
                end
                PATTERN: begin
                    if (pat_last_hit) begin
                        state_d = PRBS;
                    end
                end
                PRBS: begin
                    if (prbs_last_hit) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and output logic
    always_comb begin
        cnt_d     = cnt_q;
        np_d      = np_q;
        pattern_d = pattern_q;
        err_cnt_d = err_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mis       = 1'b0;
        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    np_d   = n_pattern;
                    busy_d = 1'b1;
                    if (n_pattern != 8'd0) begin
                        pattern_d[31:24] = IN;
                        cnt_d            = 10'd1;
                    end else begin
                        mis = prbs_mis;
                        if (ONE_PRBS) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                            cnt_d  = 10'd0;
                        end else begin
                            cnt_d = 10'd1;
                        end
                    end
                end
                LEARN: begin
                    case (cnt_q[1:0])
                        2'd1:    pattern_d[23:16] = IN;
                        2'd2:    pattern_d[15:8]  = IN;
                        2'd3:    pattern_d[7:0]   = IN;
                        default: pattern_d        = pattern_q;
                    endcase
                    cnt_d = (cnt_q[1:0] == 2'd3) ? 10'd0 : cnt_q + 10'd1;
                end
                PATTERN: begin
                    mis   = (IN != pat_byte);
                    cnt_d = pat_last_hit ? 10'd0 : cnt_q + 10'd1;
                end
                PRBS: begin
                    mis = prbs_mis;
                    if (prbs_last_hit) begin
                        cnt_d  = 10'd0;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
                default: cnt_d = 10'd0;
            endcase
            // A frame start discards the previous frame's count.
            err_cnt_d = (state_q == IDLE) ? {7'd0, mis} : sat_inc(err_cnt_q, mis);
        end
        err_d = mis;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q     <= 10'd0;
            np_q      <= 8'd0;
            pattern_q <= 32'd0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            np_q      <= np_d;
            pattern_q <= pattern_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign pattern   = pattern_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter PRBS_BYTES, default 8, giving the number of PRBS bytes checked per frame (range 1..255).
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port IN  input  8  received byte; sampled only when in_valid=1.
REQ-005 SHALL have port in_valid  input  1  qualifies IN; in_valid=0 stalls the block with no state change.
REQ-006 SHALL have port n_pattern  input  8  number of 4-byte pattern blocks per frame; sampled on the frame's first byte.
REQ-007 SHALL have port pattern  output  32  learned block, {byte0,byte1,byte2,byte3}.
REQ-008 SHALL have port err  output  1  one-cycle pulse per mismatched byte.
REQ-009 SHALL have port err_cnt  output  8  mismatches in current/last frame; saturates at 255.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a frame completes.

Function
REQ-012 SHALL implement states IDLE, LEARN, PATTERN, PRBS.
REQ-013 IDLE: the first valid byte SHALL start a frame, latch n_pattern, clear err_cnt and set busy on the next edge.
REQ-014 Start byte with latched n_pattern>=1 SHALL be stored as byte0, and the FSM SHALL go to LEARN.
REQ-015 Start byte with n_pattern=0 SHALL be checked as PRBS byte 1, and the FSM SHALL go to PRBS (or IDLE if PRBS_BYTES=1).
REQ-016 LEARN SHALL store valid bytes as byte1..byte3 without checking, then go to PATTERN if n_pattern>1, else PRBS.
REQ-017 PATTERN SHALL compare each valid byte to the learned byte at index (count mod 4) across (n_pattern-1)*4 bytes, then go to PRBS.
REQ-018 PRBS reference: 7-bit LFSR, polynomial x^7+x^6+1, reset/seed 7'h7F; each step: new=s[6]^s[5], s<={s[5:0],new}.
REQ-019 PRBS expected byte SHALL be 8 LFSR steps, first new bit in bit 7; the LFSR SHALL advance only on valid PRBS bytes.
REQ-020 The LFSR SHALL be reseeded to 7'h7F at every frame start, so the first two expected bytes are 8'h02, 8'h0C.
REQ-021 After PRBS_BYTES PRBS bytes the FSM SHALL return to IDLE, drop busy and pulse done for exactly one cycle.
REQ-022 err SHALL be registered, asserting the cycle after the mismatched byte is sampled; err_cnt SHALL update on the same edge.
REQ-023 err_cnt SHALL saturate at 8'hFF and hold its value in IDLE until the next frame starts.
REQ-024 A valid byte on the cycle done pulses SHALL start a new frame (back-to-back frames, no gap).
REQ-025 A stall of any length mid-frame SHALL NOT change state, counters, LFSR or outputs; err and done SHALL be low during stalls.
REQ-026 pattern SHALL hold its value until overwritten by LEARN of a later frame.

Reset
REQ-027 RST=0 at a rising edge SHALL force IDLE, pattern=0, err=0, err_cnt=0, busy=0, done=0, LFSR=7'h7F, all counters 0.
REQ-028 Reset SHALL take priority over in_valid; reset mid-frame SHALL abandon the frame without a done pulse.

Configuration
REQ-029 Macro PRBS_CHECK_EN defined: PRBS bytes SHALL be compared and counted per REQ-018..REQ-022.
REQ-030 Macro PRBS_CHECK_EN undefined: the LFSR SHALL be omitted, PRBS bytes SHALL only be counted (never err), and frame length and timing SHALL remain unchanged.

Verification
REQ-031 Case 1: n_pattern=1, PRBS_BYTES=2; bytes 10,AB,CD,EF,02,0C -> pattern=32'h10ABCDEF, err never set, err_cnt=0, done one cycle after 0C.
REQ-032 Case 2: n_pattern=2, bytes 10,AB,CD,EF,10,AB,00,EF,02,0C -> single err pulse the cycle after 00, final err_cnt=1.
REQ-033 Case 3: n_pattern=0, PRBS_BYTES=2; bytes 02,FF -> err after FF, err_cnt=1; with PRBS_CHECK_EN undefined, err_cnt=0.
REQ-034 Case 4: case-1 stream with in_valid=0 for 3 cycles between bytes -> identical outputs, done delayed exactly by the stall cycles.
REQ-035 Case 5: RST=0 after the third byte, then the case-1 stream -> all outputs zero after reset, second frame passes with err_cnt=0 and one done.
REQ-036 Case 6: PRBS_BYTES=255, all PRBS bytes 00 -> err_cnt saturates at 8'hFF, no wrap to 0.
